// File: rtl/tc_fetch_pkg.sv
// Shared constants and helpers for the instruction prefetch stage.
// Sizes the fetch burst, the consume field and the program counter.
package tc_fetch_pkg;

  localparam int FETCH_WORDS = 4;
  localparam int CONSUME_W   = 3;
  localparam int PC_W        = 16;

  // The decoder may present up to 7 on its 3-bit field; anything above a full window retires 4.
  function automatic logic [CONSUME_W-1:0] clamp_consume(input logic [CONSUME_W-1:0] c);
    return (c > CONSUME_W'(FETCH_WORDS)) ? CONSUME_W'(FETCH_WORDS) : c;
  endfunction

endpackage

// File: rtl/tc_word_queue.sv
// Circular word buffer: 4-word burst write at the tail, 0-4 word pop at the head.
// Exposes the 4-word head window and the occupancy count.
module tc_word_queue
  import tc_fetch_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int QUEUE_WORDS = 8,
  localparam int PTR_W      = $clog2(QUEUE_WORDS),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_flush,
  input  logic                                  i_push,
  input  logic [FETCH_WORDS-1:0][BIT_WIDTH-1:0] i_wdata,
  input  logic [CONSUME_W-1:0]                  i_pop,
  output logic [FETCH_WORDS-1:0][BIT_WIDTH-1:0] o_window,
  output logic [CNT_W-1:0]                      o_count
);

  logic [BIT_WIDTH-1:0] r_mem [QUEUE_WORDS];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  // Flush only resets the pointers; stale words are harmless because count gates validity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < QUEUE_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        for (int k = 0; k < FETCH_WORDS; k++) begin
          r_mem[r_tail + PTR_W'(k)] <= i_wdata[k];
        end
        r_tail <= r_tail + PTR_W'(FETCH_WORDS);
      end
      r_head  <= r_head + PTR_W'(i_pop);
      r_count <= r_count + (i_push ? CNT_W'(FETCH_WORDS) : CNT_W'(0)) - CNT_W'(i_pop);
    end
  end

  always_comb begin
    for (int k = 0; k < FETCH_WORDS; k++) begin
      o_window[k] = r_mem[r_head + PTR_W'(k)];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tc_prefetch_queue.sv
// Instruction prefetch stage: owns the fetch PC, fills the word queue from the 4-word ROM,
// and presents a 4-word window with its PC to the decoder; jumps flush and redirect.
module tc_prefetch_queue
  import tc_fetch_pkg::*;
#(
  parameter int              BIT_WIDTH   = 16,
  parameter int              QUEUE_WORDS = 8,
  parameter logic [PC_W-1:0] RESET_ADDR  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_W-1:0]      rom_addr,
  input  logic [BIT_WIDTH-1:0] rom_word0,
  input  logic [BIT_WIDTH-1:0] rom_word1,
  input  logic [BIT_WIDTH-1:0] rom_word2,
  input  logic [BIT_WIDTH-1:0] rom_word3,
  output logic                 instr_valid,
  output logic [BIT_WIDTH-1:0] instr_word0,
  output logic [BIT_WIDTH-1:0] instr_word1,
  output logic [BIT_WIDTH-1:0] instr_word2,
  output logic [BIT_WIDTH-1:0] instr_word3,
  output logic [PC_W-1:0]      instr_pc,
  input  logic [CONSUME_W-1:0] consume,
  input  logic                 jump_en,
  input  logic [PC_W-1:0]      jump_addr
);

  localparam int CNT_W = $clog2(QUEUE_WORDS) + 1;

  logic [PC_W-1:0]                      r_fetch_pc;
  logic [PC_W-1:0]                      r_head_pc;
  logic [CNT_W-1:0]                     w_count;
  logic [FETCH_WORDS-1:0][BIT_WIDTH-1:0] w_window;
  logic [FETCH_WORDS-1:0][BIT_WIDTH-1:0] w_rom_words;
  logic                                 w_valid;
  logic                                 w_fetch;
  logic [CONSUME_W-1:0]                 w_pop;

  assign w_rom_words = {rom_word3, rom_word2, rom_word1, rom_word0};

  // Fetch looks only at the registered count, so a same-cycle pop cannot unblock it.
  assign w_valid = (w_count >= CNT_W'(FETCH_WORDS));
  assign w_fetch = !jump_en && (w_count <= CNT_W'(QUEUE_WORDS - FETCH_WORDS));
  assign w_pop   = (w_valid && !jump_en) ? clamp_consume(consume) : '0;

  tc_word_queue #(
    .BIT_WIDTH  (BIT_WIDTH),
    .QUEUE_WORDS(QUEUE_WORDS)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_flush (jump_en),
    .i_push  (w_fetch),
    .i_wdata (w_rom_words),
    .i_pop   (w_pop),
    .o_window(w_window),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_ADDR;
      r_head_pc  <= RESET_ADDR;
    end else if (jump_en) begin
      r_fetch_pc <= jump_addr;
      r_head_pc  <= jump_addr;
    end else begin
      if (w_fetch) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(FETCH_WORDS);
      end
      r_head_pc <= r_head_pc + PC_W'(w_pop);
    end
  end

  assign rom_addr    = r_fetch_pc;
  assign instr_pc    = r_head_pc;
  assign instr_valid = w_valid;
  assign instr_word0 = w_window[0];
  assign instr_word1 = w_window[1];
  assign instr_word2 = w_window[2];
  assign instr_word3 = w_window[3];

endmodule

// File: tb/tb_tc_prefetch_queue.sv
// Directed bench for tc_prefetch_queue; the ROM model returns its own address as data.
module tb_tc_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rom_addr;
  logic [15:0] rom_word0, rom_word1, rom_word2, rom_word3;
  logic        instr_valid;
  logic [15:0] instr_word0, instr_word1, instr_word2, instr_word3;
  logic [15:0] instr_pc;
  logic [2:0]  consume = 3'd0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = 16'h0000;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rom_word0 = rom_addr;
  assign rom_word1 = rom_addr + 16'd1;
  assign rom_word2 = rom_addr + 16'd2;
  assign rom_word3 = rom_addr + 16'd3;

  tc_prefetch_queue #(
    .BIT_WIDTH  (16),
    .QUEUE_WORDS(8),
    .RESET_ADDR (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_word0  (rom_word0),
    .rom_word1  (rom_word1),
    .rom_word2  (rom_word2),
    .rom_word3  (rom_word3),
    .instr_valid(instr_valid),
    .instr_word0(instr_word0),
    .instr_word1(instr_word1),
    .instr_word2(instr_word2),
    .instr_word3(instr_word3),
    .instr_pc   (instr_pc),
    .consume    (consume),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr_pc !== 16'h0000 || rom_addr !== 16'h0000 || instr_word0 !== 16'h0000 || instr_word3 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_state: valid=%b pc=%h rom=%h w0=%h w3=%h, required 0/0000/0000/0000/0000", instr_valid, instr_pc, rom_addr, instr_word0, instr_word3);
    end
    consume = 3'd0;
    release_reset();
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || rom_addr !== 16'h0004 || instr_word0 !== 16'd0 || instr_word1 !== 16'd1 || instr_word2 !== 16'd2 || instr_word3 !== 16'd3) begin
      errors++;
      $display("[TB] FAIL first_window: valid=%b pc=%h rom=%h w=%h %h %h %h, required 1/0000/0004 w=0 1 2 3", instr_valid, instr_pc, rom_addr, instr_word0, instr_word1, instr_word2, instr_word3);
    end
    step();
    checks++;
    if (rom_addr !== 16'h0008 || instr_pc !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL second_fill: rom=%h pc=%h, required 0008/0000", rom_addr, instr_pc);
    end
    step();
    checks++;
    if (rom_addr !== 16'h0008) begin
      errors++;
      $display("[TB] FAIL full_stall: rom=%h, required 0008", rom_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 16'h0000 || instr_pc !== 16'h0000 || instr_word1 !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b rom=%h pc=%h w1=%h, required 0/0000/0000/0000", instr_valid, rom_addr, instr_pc, instr_word1);
    end
  endtask

  task automatic test_consume_one();
    logic [15:0] exp_pc;
    logic [15:0] occupancy;
    release_reset();
    step();
    consume = 3'd1;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_pc = 16'(i);
      occupancy = rom_addr - instr_pc;
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_word0 !== exp_pc || instr_word3 !== exp_pc + 16'd3) begin
        errors++;
        $display("[TB] FAIL consume1_step%0d: valid=%b pc=%h w0=%h w3=%h, required 1/%h/%h/%h", i, instr_valid, instr_pc, instr_word0, instr_word3, exp_pc, exp_pc, exp_pc + 16'd3);
      end
      checks++;
      if (occupancy > 16'd8 || occupancy < 16'd4) begin
        errors++;
        $display("[TB] FAIL consume1_occupancy%0d: count=%0d, required 4..8", i, occupancy);
      end
    end
    checks++;
    if (rom_addr !== 16'h000C) begin
      errors++;
      $display("[TB] FAIL consume1_fetch_pc: rom=%h, required 000c", rom_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pc;
    consume = 3'd4;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_pc = 16'h0008 + 16'(4 * i);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || rom_addr !== exp_pc + 16'd4 || instr_word0 !== exp_pc || instr_word2 !== exp_pc + 16'd2) begin
        errors++;
        $display("[TB] FAIL b2b_step%0d: valid=%b pc=%h rom=%h w0=%h w2=%h, required 1/%h/%h/%h/%h", i, instr_valid, instr_pc, rom_addr, instr_word0, instr_word2, exp_pc, exp_pc + 16'd4, exp_pc, exp_pc + 16'd2);
      end
    end
  endtask

  task automatic test_jump();
    jump_en = 1'b1;
    jump_addr = 16'h0100;
    consume = 3'd4;
    step();
    jump_en = 1'b0;
    checks++;
    if (rom_addr !== 16'h0100 || instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jump_redirect: rom=%h valid=%b, required 0100/0", rom_addr, instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0100 || instr_word0 !== 16'h0100 || instr_word3 !== 16'h0103 || rom_addr !== 16'h0104) begin
      errors++;
      $display("[TB] FAIL jump_window: valid=%b pc=%h w0=%h w3=%h rom=%h, required 1/0100/0100/0103/0104", instr_valid, instr_pc, instr_word0, instr_word3, rom_addr);
    end
  endtask

  task automatic test_wrap();
    jump_en = 1'b1;
    jump_addr = 16'hFFFC;
    consume = 3'd0;
    step();
    jump_en = 1'b0;
    consume = 3'd7;
    checks++;
    if (rom_addr !== 16'hFFFC || instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_redirect: rom=%h valid=%b, required fffc/0", rom_addr, instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFC || instr_word3 !== 16'hFFFF || rom_addr !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL wrap_first: valid=%b pc=%h w3=%h rom=%h, required 1/fffc/ffff/0000", instr_valid, instr_pc, instr_word3, rom_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_word0 !== 16'h0000 || rom_addr !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL wrap_clamp7: valid=%b pc=%h w0=%h rom=%h, required 1/0000/0000/0004", instr_valid, instr_pc, instr_word0, rom_addr);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0004 || instr_word1 !== 16'h0005) begin
      errors++;
      $display("[TB] FAIL wrap_continue: valid=%b pc=%h w1=%h, required 1/0004/0005", instr_valid, instr_pc, instr_word1);
    end
  endtask

  initial begin
    test_reset();
    test_consume_one();
    test_back_to_back();
    test_jump();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tc_prefetch_queue.md
# tc_prefetch_queue

Instruction prefetch stage that sits directly upstream of the 4-word program ROM (TC_ProgramWord). It owns the fetch program counter and drives the ROM address. Each cycle it captures the four words the ROM returns into a small circular word queue. It presents a 4-word window plus its PC to the decoder, which retires 0–4 words per cycle, so variable-length instructions of 1–4 words are supported. Jumps flush the queue and redirect fetch.

## Interface
- BIT_WIDTH, 16, program word width; must match the ROM.
- QUEUE_WORDS, 8, queue capacity in words; power of two, ≥ 8.
- RESET_ADDR, 16'h0000, fetch and head PC after reset.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  16  fetch address to ROM; equals fetch_pc register.
- rom_word0..rom_word3  in  BIT_WIDTH each  ROM words at rom_addr+0..+3, combinationally valid in the same cycle.
- instr_valid  out  1  the 4-word window at the queue head is fully populated.
- instr_word0..instr_word3  out  BIT_WIDTH each  queue head+0..+3.
- instr_pc  out  16  address of instr_word0.
- consume  in  3  words retired this cycle (0–4); sampled only when instr_valid=1.
- jump_en  in  1  redirect request.
- jump_addr  in  16  redirect target.

## Operation
- State registers:
  - fetch_pc (16b)
  - head_pc (16b)
  - head pointer and tail pointer (log2 QUEUE_WORDS bits each)
  - count (log2 QUEUE_WORDS + 1 bits)
  - word array (QUEUE_WORDS × BIT_WIDTH)
- Fetch rule: when jump_en=0 and (QUEUE_WORDS − count) ≥ 4, using the registered count only:
  - write rom_word0..3 to tail..tail+3 (mod QUEUE_WORDS);
  - tail += 4, fetch_pc += 4.
  - Otherwise no write; fetch_pc holds.
- Pop rule: pop = instr_valid ? min(consume, 4) : 0. Values 5–7 clamp to 4.
  - head += pop, head_pc += pop.
- Count update: count_next = count + (fetch ? 4 : 0) − pop. A fetch and a pop in the same cycle are both applied.
- instr_valid = (count ≥ 4).
- instr_word0..3 and instr_pc are driven directly from registers. There is no combinational path from any input to any output except rom_addr, which is itself a register.
- Jump: when jump_en=1, it has priority over the fetch and the pop in that cycle.
  - count, head and tail go to 0.
  - fetch_pc and head_pc load jump_addr.
  - consume is ignored and no ROM write occurs.
- Wrap-around:
  - All PC arithmetic is modulo 2^16 (0xFFFC + 4 → 0x0000).
  - Queue pointers wrap modulo QUEUE_WORDS.
- Reset: rst=1 applies asynchronously:
  - fetch_pc = head_pc = RESET_ADDR;
  - head = tail = count = 0;
  - all word entries cleared to 0, so instr_word0..3 = 0, instr_pc = RESET_ADDR, instr_valid = 0.
  - Reset asserted mid-stream discards all queued words.

## Timing
- Cycle 0 (first edge after rst deasserts): rom_addr = RESET_ADDR; the queue is written.
- Cycle 1: instr_valid=1, instr_pc = RESET_ADDR.
- Steady state with consume=4 every cycle: a fetch occurs every cycle, giving sustained throughput of 4 words/cycle with count constant at 4.
- Jump at edge N:
  - cycle N+1: rom_addr = jump_addr, instr_valid=0;
  - cycle N+2: instr_valid=1, instr_pc = jump_addr.
  - Redirect penalty is 2 cycles.
- Full queue (count > QUEUE_WORDS−4): fetch stalls; the fetch decision does not see the same-cycle pop, so at most a 1-cycle bubble results.
- Empty or partial queue (count < 4): instr_valid=0 and consume has no effect.

## Structure
- Package tc_fetch_pkg holds:
  - FETCH_WORDS = 4;
  - the consume width constant (3);
  - the PC width constant (16);
  - a clamp function for consume.
- One sub-module, tc_word_queue: a circular buffer with a 4-word write port and a 0–4-word pop, exposing the head window and count.
- The PC and jump logic stay in the top level.

## Test plan
- Reset release with RESET_ADDR=0 and ROM[i]=i: cycle 1 shows instr_valid=1, instr_pc=0, words 0,1,2,3. Asserting rst mid-stream → instr_valid=0 and rom_addr=0 immediately (asynchronous).
- consume=1 held for 8 cycles → instr_pc steps 0,1,2,…; fetch stalls whenever count > 4; count never exceeds 8; no word is lost or duplicated.
- consume=4 every cycle → rom_addr advances by 4 every cycle; instr_pc sequence 0,4,8,…; instr_valid never drops.
- jump_en=1 with jump_addr=0x0100 and consume=4 in the same cycle → the pop is ignored; next cycle rom_addr=0x0100; one cycle later instr_pc=0x0100, instr_valid=1.
- Jump to 0xFFFC → fetch wraps to rom_addr=0x0000; instr_pc sequence 0xFFFC, 0x0000 with consume=4; consume=7 behaves as 4.
